// File: rtl/vga_timing_regs.sv
// vga_timing_regs: VGA timing configuration register block.
//
// Bus writes go into a shadow register set. A write can load a full preset or
// a single field. The shadow set moves to the active set only at a frame
// boundary, or at once while the timing generator is stopped. Each time the
// active set changes, Load_config pulses for one cycle.
//
// Optional feature: define VGA_CFG_VALIDATE_EN to check the shadow set on each
// COMMIT. The check requires nonzero sync widths and porch+sync < count_max on
// both axes. A COMMIT that fails the check pulses Err and does not set Pending.
//
// Ports:
//   Clk, Rst            clock; asynchronous active-low reset
//   Valid, Addr, Data   configuration bus write (window of 10 words at BASE_ADDR)
//   Enable              timing generator running; when low, commits apply at once
//   Frame_end           one-cycle pulse on the last pixel of a frame
//   Load_config         one-cycle pulse when the active set has been updated
//   H/V_front_porch, H/V_back_porch, H/V_sync_pulse, H/V_count_max
//                       active timing set
//   Pending             a committed shadow set is waiting to be applied
//   Err                 one-cycle pulse when a write is rejected

module vga_timing_regs #(
    parameter int unsigned CONFIG_WIDTH  = 16,
    parameter int unsigned BASE_ADDR     = 16'h0002,
    parameter int unsigned PORCH_WIDTH   = 8,
    parameter int unsigned PULSE_WIDTH   = 8,
    parameter int unsigned REZ_MAX_WIDTH = 11
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Valid,
    input  logic [CONFIG_WIDTH-1:0]  Addr,
    input  logic [CONFIG_WIDTH-1:0]  Data,
    input  logic                     Enable,
    input  logic                     Frame_end,
    output logic                     Load_config,
    output logic [PORCH_WIDTH-1:0]   H_front_porch,
    output logic [PORCH_WIDTH-1:0]   H_back_porch,
    output logic [PORCH_WIDTH-1:0]   V_front_porch,
    output logic [PORCH_WIDTH-1:0]   V_back_porch,
    output logic [PULSE_WIDTH-1:0]   H_sync_pulse,
    output logic [PULSE_WIDTH-1:0]   V_sync_pulse,
    output logic [REZ_MAX_WIDTH-1:0] H_count_max,
    output logic [REZ_MAX_WIDTH-1:0] V_count_max,
    output logic                     Pending,
    output logic                     Err
);

    // Register window offsets
    localparam int unsigned OFF_PRESET = 0;
    localparam int unsigned OFF_H_FP   = 1;
    localparam int unsigned OFF_H_BP   = 2;
    localparam int unsigned OFF_V_FP   = 3;
    localparam int unsigned OFF_V_BP   = 4;
    localparam int unsigned OFF_H_SYNC = 5;
    localparam int unsigned OFF_V_SYNC = 6;
    localparam int unsigned OFF_H_MAX  = 7;
    localparam int unsigned OFF_V_MAX  = 8;
    localparam int unsigned OFF_COMMIT = 9;
    localparam int unsigned NUM_REGS   = 10;
    localparam int unsigned NUM_PRESET = 3;

    // Reset values (mode 0, 640x480)
    localparam logic [PORCH_WIDTH-1:0]   RST_H_FP   = PORCH_WIDTH'(16);
    localparam logic [PORCH_WIDTH-1:0]   RST_H_BP   = PORCH_WIDTH'(48);
    localparam logic [PORCH_WIDTH-1:0]   RST_V_FP   = PORCH_WIDTH'(10);
    localparam logic [PORCH_WIDTH-1:0]   RST_V_BP   = PORCH_WIDTH'(33);
    localparam logic [PULSE_WIDTH-1:0]   RST_H_SYNC = PULSE_WIDTH'(96);
    localparam logic [PULSE_WIDTH-1:0]   RST_V_SYNC = PULSE_WIDTH'(2);
    localparam logic [REZ_MAX_WIDTH-1:0] RST_H_MAX  = REZ_MAX_WIDTH'(799);
    localparam logic [REZ_MAX_WIDTH-1:0] RST_V_MAX  = REZ_MAX_WIDTH'(524);

    // Shadow set
    logic [PORCH_WIDTH-1:0]   sh_h_fp, sh_h_bp, sh_v_fp, sh_v_bp;
    logic [PULSE_WIDTH-1:0]   sh_h_sync, sh_v_sync;
    logic [REZ_MAX_WIDTH-1:0] sh_h_max, sh_v_max;

    // Next-state values
    logic [PORCH_WIDTH-1:0]   sh_h_fp_n, sh_h_bp_n, sh_v_fp_n, sh_v_bp_n;
    logic [PULSE_WIDTH-1:0]   sh_h_sync_n, sh_v_sync_n;
    logic [REZ_MAX_WIDTH-1:0] sh_h_max_n, sh_v_max_n;
    logic [PORCH_WIDTH-1:0]   act_h_fp_n, act_h_bp_n, act_v_fp_n, act_v_bp_n;
    logic [PULSE_WIDTH-1:0]   act_h_sync_n, act_v_sync_n;
    logic [REZ_MAX_WIDTH-1:0] act_h_max_n, act_v_max_n;
    logic                     pending_n, err_n, load_n;

    // Preset table lookup
    logic [PORCH_WIDTH-1:0]   p_h_fp, p_h_bp, p_v_fp, p_v_bp;
    logic [PULSE_WIDTH-1:0]   p_h_sync, p_v_sync;
    logic [REZ_MAX_WIDTH-1:0] p_h_max, p_v_max;

    logic [CONFIG_WIDTH-1:0]  offset;
    logic                     wr_en;
    logic                     preset_ok;
    logic                     apply;
    logic                     unused_data;

    // Decode the bus write against the register window
    assign offset    = Addr - CONFIG_WIDTH'(BASE_ADDR);
    assign wr_en     = Valid && (Addr >= CONFIG_WIDTH'(BASE_ADDR))
                             && (offset < CONFIG_WIDTH'(NUM_REGS));
    assign preset_ok = Data < CONFIG_WIDTH'(NUM_PRESET);
    assign apply     = Pending && (Frame_end || !Enable);

    // The upper data bits are truncated away on every field write
    assign unused_data = ^Data;

`ifdef VGA_CFG_VALIDATE_EN
    localparam int unsigned SUM_W = REZ_MAX_WIDTH + 1;

    logic [SUM_W-1:0] h_sum, v_sum;
    logic             cfg_ok;

    // Check the current shadow set; a COMMIT never carries field data with it
    assign h_sum  = SUM_W'(sh_h_fp) + SUM_W'(sh_h_sync) + SUM_W'(sh_h_bp);
    assign v_sum  = SUM_W'(sh_v_fp) + SUM_W'(sh_v_sync) + SUM_W'(sh_v_bp);
    assign cfg_ok = (sh_h_sync != '0) && (sh_v_sync != '0)
                 && (h_sum < SUM_W'(sh_h_max)) && (v_sum < SUM_W'(sh_v_max));
`endif

    // Preset table; an out-of-range index is rejected before this is used
    always_comb begin
        p_h_fp   = RST_H_FP;
        p_h_bp   = RST_H_BP;
        p_v_fp   = RST_V_FP;
        p_v_bp   = RST_V_BP;
        p_h_sync = RST_H_SYNC;
        p_v_sync = RST_V_SYNC;
        p_h_max  = RST_H_MAX;
        p_v_max  = RST_V_MAX;
        case (Data[1:0])
            2'd1: begin
                p_h_fp   = PORCH_WIDTH'(40);
                p_h_bp   = PORCH_WIDTH'(88);
                p_v_fp   = PORCH_WIDTH'(1);
                p_v_bp   = PORCH_WIDTH'(23);
                p_h_sync = PULSE_WIDTH'(128);
                p_v_sync = PULSE_WIDTH'(4);
                p_h_max  = REZ_MAX_WIDTH'(1055);
                p_v_max  = REZ_MAX_WIDTH'(627);
            end
            2'd2: begin
                p_h_fp   = PORCH_WIDTH'(24);
                p_h_bp   = PORCH_WIDTH'(160);
                p_v_fp   = PORCH_WIDTH'(3);
                p_v_bp   = PORCH_WIDTH'(29);
                p_h_sync = PULSE_WIDTH'(136);
                p_v_sync = PULSE_WIDTH'(6);
                p_h_max  = REZ_MAX_WIDTH'(1343);
                p_v_max  = REZ_MAX_WIDTH'(805);
            end
            default: ;
        endcase
    end

    // Next state. The apply copies the pre-write shadow. A write in the same
    // cycle then updates the shadow, and a PRESET or COMMIT re-arms Pending.
    always_comb begin
        sh_h_fp_n    = sh_h_fp;
        sh_h_bp_n    = sh_h_bp;
        sh_v_fp_n    = sh_v_fp;
        sh_v_bp_n    = sh_v_bp;
        sh_h_sync_n  = sh_h_sync;
        sh_v_sync_n  = sh_v_sync;
        sh_h_max_n   = sh_h_max;
        sh_v_max_n   = sh_v_max;
        act_h_fp_n   = H_front_porch;
        act_h_bp_n   = H_back_porch;
        act_v_fp_n   = V_front_porch;
        act_v_bp_n   = V_back_porch;
        act_h_sync_n = H_sync_pulse;
        act_v_sync_n = V_sync_pulse;
        act_h_max_n  = H_count_max;
        act_v_max_n  = V_count_max;
        pending_n    = Pending;
        err_n        = 1'b0;
        load_n       = 1'b0;

        if (apply) begin
            act_h_fp_n   = sh_h_fp;
            act_h_bp_n   = sh_h_bp;
            act_v_fp_n   = sh_v_fp;
            act_v_bp_n   = sh_v_bp;
            act_h_sync_n = sh_h_sync;
            act_v_sync_n = sh_v_sync;
            act_h_max_n  = sh_h_max;
            act_v_max_n  = sh_v_max;
            pending_n    = 1'b0;
            load_n       = 1'b1;
        end

        if (wr_en) begin
            case (offset)
                CONFIG_WIDTH'(OFF_PRESET): begin
                    if (preset_ok) begin
                        sh_h_fp_n   = p_h_fp;
                        sh_h_bp_n   = p_h_bp;
                        sh_v_fp_n   = p_v_fp;
                        sh_v_bp_n   = p_v_bp;
                        sh_h_sync_n = p_h_sync;
                        sh_v_sync_n = p_v_sync;
                        sh_h_max_n  = p_h_max;
                        sh_v_max_n  = p_v_max;
                        pending_n   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                CONFIG_WIDTH'(OFF_H_FP):   sh_h_fp_n   = PORCH_WIDTH'(Data);
                CONFIG_WIDTH'(OFF_H_BP):   sh_h_bp_n   = PORCH_WIDTH'(Data);
                CONFIG_WIDTH'(OFF_V_FP):   sh_v_fp_n   = PORCH_WIDTH'(Data);
                CONFIG_WIDTH'(OFF_V_BP):   sh_v_bp_n   = PORCH_WIDTH'(Data);
                CONFIG_WIDTH'(OFF_H_SYNC): sh_h_sync_n = PULSE_WIDTH'(Data);
                CONFIG_WIDTH'(OFF_V_SYNC): sh_v_sync_n = PULSE_WIDTH'(Data);
                CONFIG_WIDTH'(OFF_H_MAX):  sh_h_max_n  = REZ_MAX_WIDTH'(Data);
                CONFIG_WIDTH'(OFF_V_MAX):  sh_v_max_n  = REZ_MAX_WIDTH'(Data);
                CONFIG_WIDTH'(OFF_COMMIT): begin
`ifdef VGA_CFG_VALIDATE_EN
                    if (cfg_ok) begin
                        pending_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
`else
                    pending_n = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // State registers; reset restores mode 0 and raises Load_config
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sh_h_fp       <= RST_H_FP;
            sh_h_bp       <= RST_H_BP;
            sh_v_fp       <= RST_V_FP;
            sh_v_bp       <= RST_V_BP;
            sh_h_sync     <= RST_H_SYNC;
            sh_v_sync     <= RST_V_SYNC;
            sh_h_max      <= RST_H_MAX;
            sh_v_max      <= RST_V_MAX;
            H_front_porch <= RST_H_FP;
            H_back_porch  <= RST_H_BP;
            V_front_porch <= RST_V_FP;
            V_back_porch  <= RST_V_BP;
            H_sync_pulse  <= RST_H_SYNC;
            V_sync_pulse  <= RST_V_SYNC;
            H_count_max   <= RST_H_MAX;
            V_count_max   <= RST_V_MAX;
            Pending       <= 1'b0;
            Err           <= 1'b0;
            Load_config   <= 1'b1;
        end else begin
            sh_h_fp       <= sh_h_fp_n;
            sh_h_bp       <= sh_h_bp_n;
            sh_v_fp       <= sh_v_fp_n;
            sh_v_bp       <= sh_v_bp_n;
            sh_h_sync     <= sh_h_sync_n;
            sh_v_sync     <= sh_v_sync_n;
            sh_h_max      <= sh_h_max_n;
            sh_v_max      <= sh_v_max_n;
            H_front_porch <= act_h_fp_n;
            H_back_porch  <= act_h_bp_n;
            V_front_porch <= act_v_fp_n;
            V_back_porch  <= act_v_bp_n;
            H_sync_pulse  <= act_h_sync_n;
            V_sync_pulse  <= act_v_sync_n;
            H_count_max   <= act_h_max_n;
            V_count_max   <= act_v_max_n;
            Pending       <= pending_n;
            Err           <= err_n;
            Load_config   <= load_n;
        end
    end

endmodule

// File: tb/tb_vga_timing_regs.sv
// Testbench for vga_timing_regs: a cycle-by-cycle vector table plus
// hand-written reset sequences. Covers VGA_CFG_VALIDATE_EN if defined.

module tb_vga_timing_regs;

    typedef struct packed {
        int h_fp;
        int h_bp;
        int v_fp;
        int v_bp;
        int h_sync;
        int v_sync;
        int h_max;
        int v_max;
    } cfg_t;

    typedef struct {
        logic valid;
        int   addr;
        int   data;
        logic en;
        logic fe;
        logic load;
        cfg_t cfg;
        logic pend;
        logic err;
    } vec_t;

    localparam cfg_t M0 = '{16, 48, 10, 33, 96, 2, 799, 524};
    localparam cfg_t M1 = '{40, 88, 1, 23, 128, 4, 1055, 627};
    localparam cfg_t M2 = '{24, 160, 3, 29, 136, 6, 1343, 805};

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Valid = 1'b0;
    logic [15:0] Addr = '0;
    logic [15:0] Data = '0;
    logic        Enable = 1'b1;
    logic        Frame_end = 1'b0;
    logic        Load_config;
    logic [7:0]  H_front_porch, H_back_porch, V_front_porch, V_back_porch;
    logic [7:0]  H_sync_pulse, V_sync_pulse;
    logic [10:0] H_count_max, V_count_max;
    logic        Pending;
    logic        Err;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    vga_timing_regs dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Valid         (Valid),
        .Addr          (Addr),
        .Data          (Data),
        .Enable        (Enable),
        .Frame_end     (Frame_end),
        .Load_config   (Load_config),
        .H_front_porch (H_front_porch),
        .H_back_porch  (H_back_porch),
        .V_front_porch (V_front_porch),
        .V_back_porch  (V_back_porch),
        .H_sync_pulse  (H_sync_pulse),
        .V_sync_pulse  (V_sync_pulse),
        .H_count_max   (H_count_max),
        .V_count_max   (V_count_max),
        .Pending       (Pending),
        .Err           (Err)
    );

    always #5 Clk = ~Clk;

    function automatic void add(input logic valid, input int addr, input int data,
                                input logic en, input logic fe, input logic load,
                                input cfg_t cfg, input logic pend, input logic err);
        vec_t v;
        v.valid = valid;
        v.addr  = addr;
        v.data  = data;
        v.en    = en;
        v.fe    = fe;
        v.load  = load;
        v.cfg   = cfg;
        v.pend  = pend;
        v.err   = err;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic load, input cfg_t cfg,
                             input logic pend, input logic err);
        check({tag, ".load"},   int'(Load_config),   int'(load));
        check({tag, ".h_fp"},   int'(H_front_porch), cfg.h_fp);
        check({tag, ".h_bp"},   int'(H_back_porch),  cfg.h_bp);
        check({tag, ".v_fp"},   int'(V_front_porch), cfg.v_fp);
        check({tag, ".v_bp"},   int'(V_back_porch),  cfg.v_bp);
        check({tag, ".h_sync"}, int'(H_sync_pulse),  cfg.h_sync);
        check({tag, ".v_sync"}, int'(V_sync_pulse),  cfg.v_sync);
        check({tag, ".h_max"},  int'(H_count_max),   cfg.h_max);
        check({tag, ".v_max"},  int'(V_count_max),   cfg.v_max);
        check({tag, ".pend"},   int'(Pending),       int'(pend));
        check({tag, ".err"},    int'(Err),           int'(err));
    endtask

    task automatic drive(input logic valid, input int addr, input int data,
                         input logic en, input logic fe);
        Valid     = valid;
        Addr      = 16'(addr);
        Data      = 16'(data);
        Enable    = en;
        Frame_end = fe;
    endtask

    initial begin
        cfg_t m2b, m1b, m1c, m1d, mv;
        m2b = M2;  m2b.h_max = 999;
        m1b = M1;  m1b.h_fp = 255;  m1b.v_sync = 7;
        m1c = m1b; m1c.h_bp = 77;
        m1d = m1c; m1d.h_sync = 0;
        mv  = '{16, 48, 1, 23, 96, 7, 161, 627};

        // Addresses: PRESET=2, H_fp=3, H_bp=4, V_fp=5, V_bp=6, H_sync=7,
        // V_sync=8, H_max=9, V_max=10, COMMIT=11
        add(0, 0, 0, 1, 0,        0, M0,  0, 0);  // load drops after release
        add(1, 2, 2, 1, 0,        0, M0,  1, 0);  // preset 2 pending
        add(0, 0, 0, 1, 0,        0, M0,  1, 0);  // waits for frame end
        add(0, 0, 0, 1, 1,        1, M2,  0, 0);  // applied at frame end
        add(0, 0, 0, 1, 0,        0, M2,  0, 0);
        add(0, 0, 0, 1, 1,        0, M2,  0, 0);  // frame end, nothing pending
        add(1, 9, 999, 0, 0,      0, M2,  0, 0);  // field write, no commit
        add(1, 11, 'h1234, 0, 0,  0, M2,  1, 0);  // commit
        add(0, 0, 0, 0, 0,        1, m2b, 0, 0);  // enable low: applies
        add(0, 0, 0, 0, 0,        0, m2b, 0, 0);
        add(1, 2, 3, 1, 0,        0, m2b, 0, 1);  // bad preset
        add(0, 0, 0, 1, 0,        0, m2b, 0, 0);  // err is one cycle
        add(1, 12, 5, 1, 0,       0, m2b, 0, 0);  // offset 10 ignored
        add(1, 1, 0, 1, 0,        0, m2b, 0, 0);  // below window ignored
        add(1, 2, 0, 1, 0,        0, m2b, 1, 0);  // preset 0 pending
        add(1, 2, 1, 1, 1,        1, M0,  1, 0);  // apply mode 0, preset 1 rearms
        add(0, 0, 0, 1, 0,        0, M0,  1, 0);
        add(0, 0, 0, 1, 1,        1, M1,  0, 0);  // mode 1 applied
        add(1, 11, 0, 1, 0,       0, M1,  1, 0);  // commit
        add(1, 3, 'h1FF, 1, 0,    0, M1,  1, 0);  // field write while pending, truncated
        add(1, 8, 7, 1, 0,        0, M1,  1, 0);
        add(0, 0, 0, 1, 1,        1, m1b, 0, 0);  // latest shadow applied
        add(1, 11, 0, 1, 0,       0, m1b, 1, 0);
        add(1, 4, 77, 1, 1,       1, m1b, 0, 0);  // apply + field write: pend clears
        add(1, 11, 0, 1, 0,       0, m1b, 1, 0);
        add(0, 0, 0, 1, 1,        1, m1c, 0, 0);
        add(1, 7, 0, 0, 0,        0, m1c, 0, 0);  // H_sync = 0
`ifdef VGA_CFG_VALIDATE_EN
        add(1, 11, 0, 0, 0,       0, m1c, 0, 1);  // rejected: zero sync
        add(0, 0, 0, 0, 0,        0, m1c, 0, 0);
        add(1, 7, 96, 0, 0,       0, m1c, 0, 0);
        add(1, 3, 16, 0, 0,       0, m1c, 0, 0);
        add(1, 4, 48, 0, 0,       0, m1c, 0, 0);
        add(1, 9, 100, 0, 0,      0, m1c, 0, 0);
        add(1, 11, 0, 0, 0,       0, m1c, 0, 1);  // 160 >= 100
        add(1, 9, 160, 0, 0,      0, m1c, 0, 0);
        add(1, 11, 0, 0, 0,       0, m1c, 0, 1);  // 160 >= 160
        add(1, 9, 161, 0, 0,      0, m1c, 0, 0);
        add(1, 11, 0, 0, 0,       0, m1c, 1, 0);  // 160 < 161 accepted
        add(0, 0, 0, 0, 0,        1, mv,  0, 0);
`else
        add(1, 11, 0, 0, 0,       0, m1c, 1, 0);  // unchecked commit
        add(0, 0, 0, 0, 0,        1, m1d, 0, 0);
`endif

        // Held in reset
        drive(0, 0, 0, 1, 0);
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset", 1, M0, 0, 0);

        @(negedge Clk);
        Rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge Clk);
            drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].en, vecs[i].fe);
            @(posedge Clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].load, vecs[i].cfg,
                      vecs[i].pend, vecs[i].err);
        end

        // Reset while Pending=1 discards the shadow and Pending
        @(negedge Clk);
        drive(1, 2, 1, 1, 0);
        @(posedge Clk);
        #1;
        check("midrst.pend_before", int'(Pending), 1);
        @(negedge Clk);
        drive(0, 0, 0, 1, 0);
        #2;
        Rst = 1'b0;
        #1;
        check_all("midrst.async", 1, M0, 0, 0);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check_all("midrst.release", 0, M0, 0, 0);
        @(negedge Clk);
        drive(0, 0, 0, 1, 1);
        @(posedge Clk);
        #1;
        check_all("midrst.fe", 0, M0, 0, 0);

        // Shadow was restored to mode 0, not the discarded preset 1
        @(negedge Clk);
        drive(1, 11, 0, 0, 0);
        @(posedge Clk);
        #1;
        check_all("midrst.commit", 0, M0, 1, 0);
        @(negedge Clk);
        drive(0, 0, 0, 0, 0);
        @(posedge Clk);
        #1;
        check_all("midrst.apply", 1, M0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
